// File: rtl/load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_pkg
// Description : Shared definitions for the load path: funct3 load encodings,
//               controller state encoding and the latency counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package load_pkg;

    // Latency down-counter width; MEM_LAT must fit in this many bits.
    localparam int c_lat_cnt_w = 8;

    // funct3 encodings of the supported loads
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/load_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_unit_if
// Description : Request, data-memory and writeback signals of the load unit.
//               'slave' is the load unit's view, 'master' is the view of the
//               surrounding pipeline and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_base;
    logic [11:0]       req_offset;
    logic [2:0]        req_funct3;
    logic [REG_W-1:0]  req_rd;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_read_data;
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              load_err;

    modport slave (
        input  req_valid, req_base, req_offset, req_funct3, req_rd,
        output req_ready,
        output mem_read, mem_address,
        input  mem_read_data,
        output wb_valid, wb_rd, wb_data, load_err,
        input  wb_ready
    );

    modport master (
        output req_valid, req_base, req_offset, req_funct3, req_rd,
        input  req_ready,
        input  mem_read, mem_address,
        output mem_read_data,
        input  wb_valid, wb_rd, wb_data, load_err,
        output wb_ready
    );
endinterface
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Byte/halfword lane select with sign or zero extension of a
//               captured memory word. Unknown funct3 codes return the word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import load_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0] i_word,
    input  wire logic [1:0]        i_ea_lo,
    input  wire logic [2:0]        i_funct3,
    output logic      [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane, then extend according to the load type
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_word;
        case (i_ea_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_ea_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            c_f3_lb:  o_data = {{24{w_byte[7]}}, w_byte};
            c_f3_lbu: o_data = {24'h000000, w_byte};
            c_f3_lh:  o_data = {{16{w_half[15]}}, w_half};
            c_f3_lhu: o_data = {16'h0000, w_half};
            default:  o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Load-path controller. Accepts one load, forms the effective
//               address, holds mem_read for MEM_LAT cycles, then presents the
//               extended result through a valid/ready writeback handshake.
//               Optional feature macro: LOAD_MISALIGN_TRAP_EN (misaligned and
//               undefined loads skip the memory and return load_err=1).
// Revision    : 1.0 - initial release
// ============================================================================
module load_unit
    import load_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int REG_W   = 5
) (
    input  wire logic  clk,
    input  wire logic  reset,
    load_unit_if.slave bus
);

    localparam logic [c_lat_cnt_w-1:0] c_cnt_one = c_lat_cnt_w'(1);
    localparam logic [c_lat_cnt_w-1:0] c_cnt_lat = c_lat_cnt_w'(MEM_LAT);

    state_t                  r_state;
    logic [c_lat_cnt_w-1:0]  r_cnt;
    logic                    r_req_ready;
    logic                    r_mem_read;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic                    r_wb_valid;
    logic [1:0]              r_ea_lo;
    logic [2:0]              r_funct3;
    logic [REG_W-1:0]        r_rd;
    logic [DATA_W-1:0]       r_word;
    logic [ADDR_W-1:0]       w_ea;
    logic [DATA_W-1:0]       w_ext;
    logic                    w_accept;
    logic                    w_wb_done;
    logic                    w_trap;

    assign w_ea      = bus.req_base + {{(ADDR_W-12){bus.req_offset[11]}}, bus.req_offset};
    assign w_accept  = bus.req_valid && r_req_ready;
    assign w_wb_done = r_wb_valid && bus.wb_ready;

`ifdef LOAD_MISALIGN_TRAP_EN
    logic w_misalign;
    logic w_undef;
    logic r_err;

    // Classify the incoming request as misaligned or undefined
    always_comb begin
        w_misalign = 1'b0;
        w_undef    = 1'b0;
        case (bus.req_funct3)
            c_f3_lh, c_f3_lhu:      w_misalign = w_ea[0];
            c_f3_lw:                w_misalign = (w_ea[1:0] != 2'b00);
            3'b011, 3'b110, 3'b111: w_undef    = 1'b1;
            default:                ;
        endcase
    end

    assign w_trap = w_misalign || w_undef;

    // Error flag follows the trapped request until its writeback completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_trap;
        end else if (w_wb_done) begin
            r_err <= 1'b0;
        end
    end

    assign bus.load_err = r_err;
`else
    assign w_trap       = 1'b0;
    assign bus.load_err = 1'b0;
`endif

    // Control FSM: accept, time the memory access, hold the writeback result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_wb_valid  <= 1'b0;
            r_ea_lo     <= 2'b00;
            r_funct3    <= 3'b000;
            r_rd        <= '0;
            r_word      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_ea_lo     <= w_ea[1:0];
                        r_funct3    <= bus.req_funct3;
                        r_rd        <= bus.req_rd;
                        if (w_trap) begin
                            // Trapped loads never touch memory; result is zero
                            r_word     <= '0;
                            r_wb_valid <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= {w_ea[ADDR_W-1:2], 2'b00};
                            r_cnt      <= c_cnt_lat;
                            r_state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == c_cnt_one) begin
                        r_word     <= bus.mem_read_data;
                        r_mem_read <= 1'b0;
                        r_mem_addr <= '0;
                        r_wb_valid <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                RESP: begin
                    if (w_wb_done) begin
                        r_wb_valid  <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    load_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .i_word   (r_word),
        .i_ea_lo  (r_ea_lo),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    assign bus.req_ready   = r_req_ready;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_address = r_mem_addr;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_rd;
    // x0 never receives a nonzero value; data is also zero outside RESP
    assign bus.wb_data     = (r_wb_valid && (r_rd != '0)) ? w_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_unit
// Description : Scoreboard testbench for load_unit with directed loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_unit;
    import load_pkg::*;

    localparam int MEM_LAT = 3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        reset;
    int          n_vec;
    int          n_err;
    int          mem_cyc;
    logic [31:0] cur_addr;
    exp_t        sb_q[$];

    load_unit_if #(.ADDR_W(32), .DATA_W(32), .REG_W(5)) bus ();

    load_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (MEM_LAT),
        .REG_W   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model; garbage when not reading
    always_comb begin
        bus.mem_read_data = 32'hDEAD_BEEF;
        if (bus.mem_read) begin
            case (bus.mem_address)
                32'h0000_0020: bus.mem_read_data = 32'h8765_F0A1;
                32'h0000_0040: bus.mem_read_data = 32'h0000_7F80;
                default:       bus.mem_read_data = 32'h0000_0000;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: memory address while reading, scoreboard pop on writeback
    always @(negedge clk) begin
        if (reset) begin
            mem_cyc = 0;
        end else begin
            if (bus.mem_read) begin
                mem_cyc++;
                check("mem_address", bus.mem_address, cur_addr);
            end else begin
                check("mem_address_idle", bus.mem_address, 32'h0);
            end
            if (bus.wb_valid && bus.wb_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_wb", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wb_rd", {27'h0, bus.wb_rd}, {27'h0, e.rd});
                    check("wb_data", bus.wb_data, e.data);
                    check("load_err", {31'h0, bus.load_err}, {31'h0, e.err});
                    check("mem_read_cycles", mem_cyc, e.cycles);
                end
                mem_cyc = 0;
            end
        end
    end

    // Issue one load, record its expectation, and check wb_valid latency
    task automatic issue(input logic [31:0] base, input logic [11:0] off,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_cyc, input logic [31:0] exp_addr);
        int   t;
        exp_t e;
        @(negedge clk);
        t = 0;
        while (!bus.req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("req_ready_timeout", 32'h0, 32'h1);
            return;
        end
        cur_addr = exp_addr;
        e.rd = rd; e.data = exp_data; e.err = exp_err; e.cycles = exp_cyc;
        sb_q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_funct3 = f3;
        bus.req_rd     = rd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        t = 1;
        @(negedge clk);
        while (!bus.wb_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("wb_latency", t, exp_cyc + 1);
    endtask

    task automatic check_all_zero(input string tag, input logic with_ready);
        if (with_ready) check({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h0);
        check({tag, "_mem_read"}, {31'h0, bus.mem_read}, 32'h0);
        check({tag, "_mem_address"}, bus.mem_address, 32'h0);
        check({tag, "_wb_valid"}, {31'h0, bus.wb_valid}, 32'h0);
        check({tag, "_wb_rd"}, {27'h0, bus.wb_rd}, 32'h0);
        check({tag, "_wb_data"}, bus.wb_data, 32'h0);
        check({tag, "_load_err"}, {31'h0, bus.load_err}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int wb_seen;
        n_vec = 0; n_err = 0; mem_cyc = 0; cur_addr = 32'h0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_base = '0; bus.req_offset = '0;
        bus.req_funct3 = '0; bus.req_rd = '0; bus.wb_ready = 1'b1;

        // Reset state, while asserted and in the cycle after
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset", 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset", 1'b0);

        // Word, byte and halfword loads
        issue(32'h20, 12'h000, c_f3_lw,  5'd7,  32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h20, 12'h000, c_f3_lb,  5'd1,  32'hFFFF_FFA1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h20, 12'h000, c_f3_lbu, 5'd2,  32'h0000_00A1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h20, 12'h001, c_f3_lb,  5'd3,  32'hFFFF_FFF0, 1'b0, MEM_LAT, 32'h20);
        issue(32'h20, 12'h003, c_f3_lb,  5'd4,  32'hFFFF_FF87, 1'b0, MEM_LAT, 32'h20);
        issue(32'h24, 12'hFFE, c_f3_lh,  5'd5,  32'hFFFF_8765, 1'b0, MEM_LAT, 32'h20);
        issue(32'h24, 12'hFFE, c_f3_lhu, 5'd6,  32'h0000_8765, 1'b0, MEM_LAT, 32'h20);
        issue(32'h20, 12'h000, c_f3_lhu, 5'd8,  32'h0000_F0A1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h40, 12'h000, c_f3_lh,  5'd9,  32'h0000_7F80, 1'b0, MEM_LAT, 32'h40);
        issue(32'h40, 12'h000, c_f3_lb,  5'd10, 32'hFFFF_FF80, 1'b0, MEM_LAT, 32'h40);
        issue(32'h40, 12'h001, c_f3_lbu, 5'd11, 32'h0000_007F, 1'b0, MEM_LAT, 32'h40);
        // Address wrap and most negative offset
        issue(32'hFFFF_FFFF, 12'h021, c_f3_lbu, 5'd12, 32'h0000_00A1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h820, 12'h800, c_f3_lw, 5'd13, 32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);
        // Destination x0 still produces a writeback, with zero data
        issue(32'h20, 12'h000, c_f3_lw, 5'd0, 32'h0, 1'b0, MEM_LAT, 32'h20);

        // Misaligned and undefined loads
`ifdef LOAD_MISALIGN_TRAP_EN
        issue(32'h20, 12'h001, c_f3_lw, 5'd14, 32'h0, 1'b1, 0, 32'h0);
        issue(32'h20, 12'h001, c_f3_lh, 5'd15, 32'h0, 1'b1, 0, 32'h0);
        issue(32'h20, 12'h000, 3'b011,  5'd16, 32'h0, 1'b1, 0, 32'h0);
        issue(32'h22, 12'h000, 3'b110,  5'd17, 32'h0, 1'b1, 0, 32'h0);
`else
        issue(32'h20, 12'h001, c_f3_lw, 5'd14, 32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h20, 12'h001, c_f3_lh, 5'd15, 32'hFFFF_F0A1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h20, 12'h000, 3'b011,  5'd16, 32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);
        issue(32'h22, 12'h000, 3'b110,  5'd17, 32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);
`endif
        // Aligned load after the exceptional cases
        issue(32'h1C, 12'h004, c_f3_lw, 5'd18, 32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);

        // Writeback stall with an extra request pulse that must be ignored
        @(posedge clk);
        #1 bus.wb_ready = 1'b0;
        issue(32'h20, 12'h000, c_f3_lw, 5'd3, 32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);
        for (int i = 0; i < 5; i++) begin
            check("stall_wb_valid", {31'h0, bus.wb_valid}, 32'h1);
            check("stall_wb_data", bus.wb_data, 32'h8765_F0A1);
            check("stall_wb_rd", {27'h0, bus.wb_rd}, 32'd3);
            check("stall_req_ready", {31'h0, bus.req_ready}, 32'h0);
            check("stall_mem_read", {31'h0, bus.mem_read}, 32'h0);
            bus.req_valid  = (i >= 1 && i <= 3);
            bus.req_base   = 32'h40;
            bus.req_offset = 12'h000;
            bus.req_funct3 = c_f3_lb;
            bus.req_rd     = 5'd12;
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.wb_ready = 1'b1;
        issue(32'h40, 12'h000, c_f3_lhu, 5'd19, 32'h0000_7F80, 1'b0, MEM_LAT, 32'h40);

        // Reset in the second access cycle abandons the load
        @(negedge clk);
        t = 0;
        while (!bus.req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        cur_addr = 32'h20;
        bus.req_valid  = 1'b1;
        bus.req_base   = 32'h20;
        bus.req_offset = 12'h000;
        bus.req_funct3 = c_f3_lw;
        bus.req_rd     = 5'd9;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset", 1'b1);
        wb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wb_valid) wb_seen++;
        end
        check("abandoned_wb_count", wb_seen, 0);
        issue(32'h20, 12'h000, c_f3_lw, 5'd7, 32'h8765_F0A1, 1'b0, MEM_LAT, 32'h20);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_unit.md
# load_unit

Load-path controller between the execute stage and `data_memory`. It accepts one load request per handshake, forms the effective address, and drives `mem_read`/`address` on the data memory for a fixed latency. It then extracts and sign- or zero-extends the addressed byte, halfword or word, and presents the result to register-file writeback through a valid/ready handshake.

## Interface
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, memory and register data width; fixed at 32.
- `MEM_LAT`, 1, number of cycles `mem_read` is held per access; must be ≥1.
- `REG_W`, 5, width of the destination register index.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  load request present.
- `req_ready`  out  1  unit idle and accepting a request.
- `req_base`  in  ADDR_W  base register value.
- `req_offset`  in  12  signed immediate offset.
- `req_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `req_rd`  in  REG_W  destination register.
- `mem_read`  out  1  read enable to `data_memory`.
- `mem_address`  out  ADDR_W  word-aligned byte address to `data_memory`.
- `mem_read_data`  in  DATA_W  `data_memory` read data.
- `wb_valid`  out  1  writeback result valid.
- `wb_ready`  in  1  writeback consumer accepts.
- `wb_rd`  out  REG_W  destination register of the result.
- `wb_data`  out  DATA_W  extended load result.
- `load_err`  out  1  error flag qualified by `wb_valid`.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch the following, then go to ACCESS:
    - ea = `req_base` + sign-extended `req_offset`, modulo 2^ADDR_W;
    - `req_funct3`;
    - `req_rd`.
- **ACCESS**
  - `mem_read`=1.
  - `mem_address` = {ea[ADDR_W-1:2], 2'b00}.
  - Down-counter loaded with MEM_LAT and decremented each cycle.
  - When the count reaches its last cycle, capture `mem_read_data` into the result register and go to RESP.
- **RESP**
  - `wb_valid`=1.
  - `wb_rd`, `wb_data` and `load_err` are held stable until `wb_valid`&&`wb_ready`, then the unit returns to IDLE.
- Extraction from the captured word w:
  - LB: sign-extend byte lane ea[1:0].
  - LBU: zero-extend byte lane ea[1:0].
  - LH: sign-extend halfword lane ea[1].
  - LHU: zero-extend halfword lane ea[1].
  - LW: w.
- When `wb_rd`==0, `wb_data` is forced to 0 and `wb_valid` is still raised.
- One request is outstanding at a time. `req_valid` outside IDLE is ignored, and the request is not consumed.

## Timing
- Accept at edge T. ACCESS occupies cycles T+1..T+MEM_LAT. `wb_valid` rises at T+MEM_LAT+1.
- Minimum throughput is one load per MEM_LAT+2 cycles.
- While `reset` is high, and in the cycle after it:
  - `req_ready`=0 while reset is high;
  - `mem_read`=0, `mem_address`=0;
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0;
  - `load_err`=0.
- Reset asserted mid-ACCESS or mid-RESP abandons the load: no `wb_valid` is produced for it, and the state returns to IDLE.
- `mem_read`=0 and `mem_address`=0 in IDLE and RESP.
- No combinational path from `req_*` to `mem_*` or `wb_*`.

## Configuration
- Controlled by `LOAD_MISALIGN_TRAP_EN`.
- **Defined:**
  - Misaligned accesses are LH/LHU with ea[0]=1, and LW with ea[1:0]≠0.
  - Undefined funct3 values are 011, 110 and 111.
  - On accept, either case skips ACCESS: `mem_read` is never asserted, and the unit enters RESP next cycle with `wb_data`=0 and `load_err`=1.
- **Undefined:**
  - `load_err` is tied to 0.
  - Misaligned loads are accessed at the aligned word and extracted by lane as above; LW ignores ea[1:0].
  - funct3 011, 110 and 111 behave as LW.

## Structure
- Shared package `load_pkg` holds:
  - funct3 load encodings;
  - the state enum {IDLE, ACCESS, RESP};
  - the MEM_LAT counter width.
- Sub-module `load_extract`: combinational lane select and extension. Inputs are w, ea[1:0] and funct3; output is `wb_data`. It is instantiated once, on the captured word.

## Test plan
- **LW:** word 0x8765F0A1 at 0x20; LW with base 0x20, offset 0, rd 7 → `mem_address`=0x20, `mem_read` high for MEM_LAT cycles, `wb_data`=0x8765F0A1, `wb_rd`=7.
- **Byte loads:** same memory; LB at ea 0x20 → 0xFFFFFFA1; LBU at ea 0x20 → 0x000000A1; LB at ea 0x21 → 0xFFFFFFF0.
- **Halfword loads and negative offset:** LH with base 0x24, offset −2 → ea 0x22, `mem_address`=0x20, `wb_data`=0xFFFF8765; LHU at the same ea → 0x00008765.
- **Writeback stall:** hold `wb_ready` low for 5 cycles and pulse `req_valid` → `wb_valid` and `wb_data` are stable, `req_ready`=0, and the extra request is not accepted. Accept occurs only after the handshake completes.
- **Misaligned LW, ea 0x21:**
  - with `LOAD_MISALIGN_TRAP_EN` → no `mem_read`, `load_err`=1, `wb_data`=0;
  - without it → `mem_address`=0x20, `wb_data`=0x8765F0A1.
- **Reset mid-access:** with MEM_LAT=3, assert `reset` in the second ACCESS cycle → all outputs 0 next cycle, no `wb_valid` ever produced for that load, and a following LW completes normally.
